// File: rtl/etroc_frame_gearbox_pkg.sv
// -----------------------------------------------------------------------------
// etroc_frame_gearbox_pkg
// Shared constants and helpers for the ETROC frame gearbox.
//   FRAME_W   : width of one emitted frame (bits)
//   BUF_W     : width of the bit-accumulation buffer
//   FILL_W    : width of the buffer occupancy counter
//   CNT_W     : width of the emitted-frame counter
//   RATE_*    : dataRate encodings (8 / 16 / 32 valid bits per cycle)
// -----------------------------------------------------------------------------
package etroc_frame_gearbox_pkg;

   localparam int FRAME_W = 40;
   localparam int BUF_W   = 72;
   localparam int FILL_W  = 7;
   localparam int CNT_W   = 16;

   localparam logic [1:0] RATE_320  = 2'b00;
   localparam logic [1:0] RATE_640  = 2'b01;
   localparam logic [1:0] RATE_1280 = 2'b10;

   // Number of valid din bits per cycle; both upper encodings mean 32 bits.
   function automatic logic [FILL_W-1:0] rate_bits(input logic [1:0] rate);
      case (rate)
         RATE_320: rate_bits = 7'd8;
         RATE_640: rate_bits = 7'd16;
         default:  rate_bits = 7'd32;
      endcase
   endfunction

   // Mask that keeps only the valid low bits of din for the given rate.
   function automatic logic [31:0] rate_mask(input logic [1:0] rate);
      case (rate)
         RATE_320: rate_mask = 32'h0000_00FF;
         RATE_640: rate_mask = 32'h0000_FFFF;
         default:  rate_mask = 32'hFFFF_FFFF;
      endcase
   endfunction

endpackage

// File: rtl/etroc_frame_gearbox.sv
// -----------------------------------------------------------------------------
// etroc_frame_gearbox
// Packs a rate-compacted bit stream (8/16/32 bits per cycle) into 40-bit
// frames. Each cycle: append din's valid bits above the current fill, then
// optionally drop the oldest bit (bitSlip), then emit a frame if >= 40 bits
// are buffered. A change of dataRate flushes the buffer.
//
// Ports
//   clk        : clock
//   rstn       : asynchronous active-low reset
//   dataRate   : 00 = 8 bits/cycle, 01 = 16, 10/11 = 32
//   din        : input word, valid bits in din[N-1:0], din[0] earliest
//   bitSlip    : one-cycle pulse, discard the oldest buffered bit
//   dout       : assembled frame, dout[0] earliest bit; holds when not valid
//   doutValid  : one-cycle strobe qualifying dout
//   frameCnt   : number of frames emitted (wraps)
//   fillLevel  : current buffer occupancy in bits (debug)
// -----------------------------------------------------------------------------
module etroc_frame_gearbox
   import etroc_frame_gearbox_pkg::*;
(
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [1:0]           dataRate,
   input  logic [31:0]          din,
   input  logic                 bitSlip,
   output logic [FRAME_W-1:0]   dout,
   output logic                 doutValid,
   output logic [CNT_W-1:0]     frameCnt,
   output logic [FILL_W-1:0]    fillLevel
);

   logic [BUF_W-1:0]  buffer;
   logic [FILL_W-1:0] fill;
   logic [1:0]        prev_rate;

   logic [BUF_W-1:0]  buf_app, buf_slip, buf_next;
   logic [FILL_W-1:0] fill_app, fill_slip, fill_next;
   logic              emit;
   logic              rate_chg;

   // Append -> slip -> emit, all combinational on the registered buffer.
   // NOTE: every always_comb output gets a default first so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      buf_app   = '0;
      fill_app  = '0;
      buf_slip  = '0;
      fill_slip = '0;
      buf_next  = '0;
      fill_next = '0;
      emit      = 1'b0;

      // Bits above fill are always zero, so OR-ing the shifted word appends.
      buf_app  = buffer | (BUF_W'(din & rate_mask(dataRate)) << fill);
      fill_app = fill + rate_bits(dataRate);

      // fill_app >= 8 here, so a slip always has a bit to discard.
      if (bitSlip) begin
         buf_slip  = buf_app >> 1;
         fill_slip = fill_app - 7'd1;
      end else begin
         buf_slip  = buf_app;
         fill_slip = fill_app;
      end

      emit = (fill_slip >= FILL_W'(FRAME_W));
      if (emit) begin
         buf_next  = buf_slip >> FRAME_W;
         fill_next = fill_slip - FILL_W'(FRAME_W);
      end else begin
         buf_next  = buf_slip;
         fill_next = fill_slip;
      end
   end

   assign rate_chg  = (dataRate != prev_rate);
   assign fillLevel = fill;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   // NOTE: the buffer is cleared on reset (not left uninitialised) because
   // the OR-based append relies on all bits above fill being zero.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         buffer    <= '0;
         fill      <= '0;
         prev_rate <= RATE_320;
         dout      <= '0;
         doutValid <= 1'b0;
         frameCnt  <= '0;
      end else begin
         prev_rate <= dataRate;
         doutValid <= 1'b0;
         if (rate_chg) begin
            // Rate switch: drop everything, including this cycle's din.
            buffer <= '0;
            fill   <= '0;
         end else begin
            buffer <= buf_next;
            fill   <= fill_next;
            if (emit) begin
               dout      <= buf_slip[FRAME_W-1:0];
               doutValid <= 1'b1;
               frameCnt  <= frameCnt + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: doc/etroc_frame_gearbox.md
ETROC_FRAME_GEARBOX -- requirements
Module: etroc_frame_gearbox

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1, rstn input 1.
REQ-002 dataRate SHALL be an input, 2 bits: 00 = 8 valid bits/cycle, 01 = 16, 10/11 = 32.
REQ-003 din SHALL be an input, 32 bits: rate-compacted word from the data extender, valid bits in din[N-1:0], din[0] earliest in time.
REQ-004 bitSlip SHALL be an input, 1 bit, single-cycle pulse requesting a one-bit discard.
REQ-005 dout SHALL be an output, 40 bits: assembled frame, dout[0] earliest bit.
REQ-006 doutValid SHALL be an output, 1 bit: one-cycle strobe qualifying dout.
REQ-007 frameCnt SHALL be an output, 16 bits: count of emitted frames, wraps 0xFFFF->0x0000.
REQ-008 fillLevel SHALL be an output, 7 bits: current buffer occupancy in bits, for debug.

Function
REQ-009 The block SHALL accept N bits from din every clk cycle, with N=8/16/32 from dataRate; there is no input valid and no backpressure.
REQ-010 Bits SHALL be stored in a 72-bit buffer at positions [fill+N-1:fill], oldest bit at position 0.
REQ-011 Per-cycle order SHALL be: append N bits, then apply bitSlip, then emit.
REQ-012 bitSlip SHALL discard the oldest buffered bit (shift right by 1, fill-1); fill after append is always >= 8, so the slip always applies.
REQ-013 When post-slip fill >= 40, the block SHALL register buffer[39:0] onto dout, assert doutValid for one cycle, shift the buffer right by 40 and subtract 40 from fill.
REQ-014 Fill SHALL stay within 0..39 between cycles and never exceed 71 during a cycle; no overflow is possible.
REQ-015 Latency SHALL be one clk: doutValid rises on the edge after the cycle whose din completes the frame.
REQ-016 dout SHALL hold its last value while doutValid=0.
REQ-017 A change of dataRate (registered compare against previous value) SHALL flush the buffer (fill=0), discard that cycle's din, suppress doutValid for that cycle, and leave frameCnt unchanged.
REQ-018 frameCnt SHALL increment by 1 on every doutValid.
REQ-019 Steady-state frame rate SHALL be 1 frame per 5 cycles at 8 bits, 2 per 5 at 16 bits, and 4 per 5 at 32 bits.

Reset
REQ-020 While rstn=0, the block SHALL hold dout=0, doutValid=0, frameCnt=0, fillLevel=0, buffer=0, and previous-dataRate register=din rate 00.
REQ-021 Reset assertion mid-frame SHALL discard partial data immediately; after release, the first append is at fill=0.
REQ-022 The first cycle after reset release SHALL NOT be treated as a dataRate change unless dataRate differs from 00.

Structure
REQ-023 The shared package SHALL hold FRAME_W=40, BUF_W=72, FILL_W=7, CNT_W=16, and rate encodings RATE_320=2'b00, RATE_640=2'b01, RATE_1280=2'b10.
REQ-024 The block SHALL be a single module with no sub-module; the append, slip and emit shifts are combinational inside it, and all state is in one always block.

Verification
REQ-025 Rate 10, din=32-bit incrementing bit pattern for 5 cycles: 4 doutValid pulses, the concatenated dout equals the 160-bit input stream, and fill returns to 0.
REQ-026 Rate 00, din[7:0]=0x01,0x02,0x03,0x04,0x05: exactly one doutValid after the 5th word, with dout=0x0504030201.
REQ-027 Rate 01, 10 cycles: doutValid after cycles 3, 5, 8 and 10, and frameCnt=4.
REQ-028 Rate 10, bitSlip in cycle 1: the output stream is the input stream shifted by 1 bit; 40 slips restore the original frame alignment (with frameCnt offset by 1).
REQ-029 Rate 10, switch to 00 at fill=24: no valid in the switch cycle, fill=0, and the next frame completes 5 cycles later.
REQ-030 rstn pulsed low at fill=32: all outputs go to 0 asynchronously; after release, the rate-10 stream produces its first frame 2 cycles later.
